// File: rtl/name_deserializer.sv
// Assembles a valid/ready/last word stream into a parallel name for the FIB lookup.
// Output appears one edge after the last word; in_ready drops while a finished name waits for the output slot.
module name_deserializer #(
  parameter int WORD_SIZE       = 64,
  parameter int MAX_NAME_LENGTH = 16,
  parameter int LEN_W           = $clog2(MAX_NAME_LENGTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [WORD_SIZE-1:0]                 in_word,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] name_out,
  output logic [LEN_W-1:0]                     name_len,
  output logic                                 name_trunc,
  output logic                                 name_valid,
  input  logic                                 name_ready
);

  localparam int              IDX_W   = (MAX_NAME_LENGTH > 1) ? $clog2(MAX_NAME_LENGTH) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_NAME_LENGTH);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

  logic [0:0]           state;
  logic [LEN_W-1:0]     idx;
  logic [LEN_W-1:0]     hold_len;
  logic                 trunc_q;
  logic [WORD_SIZE-1:0] asm_buf [MAX_NAME_LENGTH];
  logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] asm_flat;

  logic accept;
  logic idx_in_range;
  logic slot_free;
  logic xfer;

  // in_ready depends only on registered state, never on in_valid.
  assign in_ready     = (state == ST_COLLECT);
  assign accept       = in_valid && in_ready;
  assign idx_in_range = (idx < MAX_LEN);
  assign slot_free    = !name_valid || name_ready;
  assign xfer         = (state == ST_HOLD) && slot_free;

  for (genvar g = 0; g < MAX_NAME_LENGTH; g++) begin : g_flat
    assign asm_flat[g*WORD_SIZE +: WORD_SIZE] = asm_buf[g];
  end

  // Assembly buffer is wiped on every transfer so unused words read back as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_COLLECT;
      idx      <= '0;
      hold_len <= '0;
      trunc_q  <= 1'b0;
      for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
        asm_buf[i] <= '0;
      end
    end else if (xfer) begin
      state   <= ST_COLLECT;
      idx     <= '0;
      trunc_q <= 1'b0;
      for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
        asm_buf[i] <= '0;
      end
    end else if (accept) begin
      if (idx_in_range) begin
        asm_buf[idx[IDX_W-1:0]] <= in_word;
        idx                     <= idx + LEN_W'(1);
      end else begin
        trunc_q <= 1'b1;
      end
      if (in_last) begin
        state    <= ST_HOLD;
        hold_len <= idx_in_range ? (idx + LEN_W'(1)) : MAX_LEN;
      end
    end
  end

  // Output slot: a transfer in the same cycle as a consume keeps name_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      name_out   <= '0;
      name_len   <= '0;
      name_trunc <= 1'b0;
      name_valid <= 1'b0;
    end else if (xfer) begin
      name_out   <= asm_flat;
      name_len   <= hold_len;
      name_trunc <= trunc_q;
      name_valid <= 1'b1;
    end else if (name_valid && name_ready) begin
      name_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_name_deserializer.sv
// Scoreboard bench for name_deserializer: names pushed when driven, checked when consumed.
module tb_name_deserializer;
  localparam int WS = 64;
  localparam int ML = 16;
  localparam int LW = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WS-1:0]    in_word = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [ML*WS-1:0] name_out;
  logic [LW-1:0]    name_len;
  logic             name_trunc;
  logic             name_valid;
  logic             name_ready = 1'b0;

  typedef struct packed {
    logic [ML*WS-1:0] words;
    logic [LW-1:0]    len;
    logic             trunc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [WS-1:0] stim [0:31];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            start_cyc;

  name_deserializer #(.WORD_SIZE(WS), .MAX_NAME_LENGTH(ML), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .name_out(name_out), .name_len(name_len), .name_trunc(name_trunc),
    .name_valid(name_valid), .name_ready(name_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic drive_word(input logic [WS-1:0] w, input logic last);
    int cnt = 0;
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    while (!in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_name(input int n);
    exp_t e;
    e.words = '0;
    for (int i = 0; i < n && i < ML; i++) e.words[i*WS +: WS] = stim[i];
    e.len   = LW'((n > ML) ? ML : n);
    e.trunc = (n > ML);
    sb.push_back(e);
    for (int i = 0; i < n; i++) drive_word(stim[i], i == n - 1);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Inputs change at negedge; sampling 1 unit later sees what the next edge will use.
  always @(negedge clk) begin
    #1;
    if (rst_n && name_valid && name_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd0, 64'd1);
      end else begin
        mon_e = sb.pop_front();
        for (int i = 0; i < ML; i++)
          chk($sformatf("word%0d", i), name_out[i*WS +: WS], mon_e.words[i*WS +: WS]);
        chk("name_len", 64'(name_len), 64'(mon_e.len));
        chk("name_trunc", 64'(name_trunc), 64'(mon_e.trunc));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(name_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_len", 64'(name_len), 64'd0);
    chk("rst_trunc", 64'(name_trunc), 64'd0);
    chk("rst_word0", name_out[WS-1:0], 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3-word name with latency checks
    name_ready = 1'b1;
    stim[0] = 64'hA; stim[1] = 64'hB; stim[2] = 64'hC;
    send_name(3);
    chk("lat_valid_early", 64'(name_valid), 64'd0);
    chk("lat_in_ready_hold", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(name_valid), 64'd1);
    chk("lat_in_ready_back", 64'(in_ready), 64'd1);
    drain();

    // single-word name
    stim[0] = 64'h1234;
    send_name(1);
    drain();

    // truncation then a short clean name
    for (int i = 0; i < 18; i++) stim[i] = 64'(i + 1);
    send_name(18);
    stim[0] = 64'hE1; stim[1] = 64'hE2;
    send_name(2);
    drain();

    // back-pressure: A held, B waits in HOLD
    name_ready = 1'b0;
    stim[0] = 64'hA1; stim[1] = 64'hA2;
    send_name(2);
    stim[0] = 64'hB1; stim[1] = 64'hB2; stim[2] = 64'hB3; stim[3] = 64'hB4;
    send_name(4);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(name_valid), 64'd1);
      chk("bp_hold_w0", name_out[WS-1:0], 64'hA1);
      chk("bp_hold_w1", name_out[2*WS-1:WS], 64'hA2);
      chk("bp_hold_len", 64'(name_len), 64'd2);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    name_ready = 1'b1;
    @(negedge clk);
    name_ready = 1'b0;
    chk("bp_swap_valid", 64'(name_valid), 64'd1);
    chk("bp_swap_w0", name_out[WS-1:0], 64'hB1);
    chk("bp_swap_len", 64'(name_len), 64'd4);
    chk("bp_swap_in_ready", 64'(in_ready), 64'd1);
    name_ready = 1'b1;
    @(negedge clk);
    name_ready = 1'b0;
    chk("bp_empty_valid", 64'(name_valid), 64'd0);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // streaming 16,1,5 with name_ready high
    name_ready = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < 16; i++) stim[i] = 64'(32'h100 + i);
    send_name(16);
    stim[0] = 64'h200;
    send_name(1);
    for (int i = 0; i < 5; i++) stim[i] = 64'(32'h300 + i);
    send_name(5);
    @(negedge clk);
    chk("stream_cycles", 64'(cyc - start_cyc), 64'd25);
    drain();

    // async reset mid-name with a name held in the output slot
    name_ready = 1'b0;
    stim[0] = 64'h77; stim[1] = 64'h78;
    send_name(2);
    for (int i = 0; i < 7; i++) drive_word(64'(32'h900 + i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(name_valid), 64'd0);
    chk("arst_len", 64'(name_len), 64'd0);
    chk("arst_trunc", 64'(name_trunc), 64'd0);
    chk("arst_word0", name_out[WS-1:0], 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    name_ready = 1'b1;
    stim[0] = 64'h5; stim[1] = 64'h6;
    send_name(2);
    drain();
    @(negedge clk);
    chk("end_valid", 64'(name_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
